// File: rtl/types_pkg.sv
// Shared CSR datapath types: address, data word, register index and op code.
// Pure type definitions, no timing.
// No flow control.
package types_pkg;

   typedef logic [11:0] CsrAddrT;
   typedef logic [31:0] word;
   typedef logic [4:0]  r;

   // funct3 encoding of the Zicsr instructions; 0 is unused by hardware ops
   typedef enum logic [2:0] {
      CSR_NONE = 3'd0,
      CSRRW    = 3'd1,
      CSRRS    = 3'd2,
      CSRRC    = 3'd3,
      CSRRWI   = 3'd5,
      CSRRSI   = 3'd6,
      CSRRCI   = 3'd7
   } csr_op_t;

endpackage

// File: rtl/csr_arbiter.sv
// Two-port (core/ext) round-robin arbiter in front of a single CSR bank.
// Latency: grant -> csr_enable 1 cycle, response 2 cycles after grant; 3 cycles grant to next grant minimum.
// Backpressure: one access in flight; response held until granted port's rsp_ready, requests ignored outside IDLE.
module csr_arbiter #(
   parameter bit  ExtFirst = 1'b0,
   parameter type CsrAddrT = types_pkg::CsrAddrT
) (
   input  logic              clk,
   input  logic              reset_n,

   input  logic              core_valid,
   output logic              core_ready,
   input  CsrAddrT           core_addr,
   input  types_pkg::csr_op_t core_op,
   input  types_pkg::r       core_zimm,
   input  types_pkg::word    core_data,

   output logic              core_rsp_valid,
   input  logic              core_rsp_ready,
   output types_pkg::word    core_rsp_data,
   output logic              core_rsp_err,

   input  logic              ext_valid,
   output logic              ext_ready,
   input  CsrAddrT           ext_addr,
   input  types_pkg::csr_op_t ext_op,
   input  types_pkg::r       ext_zimm,
   input  types_pkg::word    ext_data,

   output logic              ext_rsp_valid,
   input  logic              ext_rsp_ready,
   output types_pkg::word    ext_rsp_data,
   output logic              ext_rsp_err,

   output logic              csr_enable,
   output CsrAddrT           csr_addr,
   output types_pkg::csr_op_t csr_op,
   output types_pkg::r       rs1_zimm,
   output types_pkg::word    rs1_data,
   input  types_pkg::word    csr_rdata,
   input  logic              csr_hit
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               grant_q;     // port owning the in-flight access: 0 core, 1 ext
   logic               last_q;      // port that won the last completed access
   logic               pick_ext;
   logic               take;
   logic               rsp_done;

   CsrAddrT            addr_q;
   types_pkg::csr_op_t op_q;
   types_pkg::r        zimm_q;
   types_pkg::word     data_q;
   types_pkg::word     rdata_q;
   logic               err_q;

   // ext wins when it is alone, or when both ask and core won last time
   assign pick_ext = ext_valid && (!core_valid || !last_q);

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state and handshake outputs; ready is masked during reset so no grant can happen there
   always_comb begin
      state_d        = state_q;
      core_ready     = 1'b0;
      ext_ready      = 1'b0;
      core_rsp_valid = 1'b0;
      ext_rsp_valid  = 1'b0;
      csr_enable     = 1'b0;
      take           = 1'b0;
      rsp_done       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if ((core_valid || ext_valid) && reset_n) begin
               take    = 1'b1;
               state_d = ISSUE;
               if (pick_ext) begin
                  ext_ready = 1'b1;
               end else begin
                  core_ready = 1'b1;
               end
            end
         end
         ISSUE: begin
            csr_enable = 1'b1;
            state_d    = RESP;
         end
         RESP: begin
            if (grant_q) begin
               ext_rsp_valid = 1'b1;
               rsp_done      = ext_rsp_ready;
            end else begin
               core_rsp_valid = 1'b1;
               rsp_done       = core_rsp_ready;
            end
            if (rsp_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // request capture on grant, bank result capture on the issue cycle, pointer update on completion
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_q <= 1'b0;
         last_q  <= !ExtFirst;
         addr_q  <= '0;
         op_q    <= types_pkg::CSR_NONE;
         zimm_q  <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (take) begin
            grant_q <= pick_ext;
            addr_q  <= pick_ext ? ext_addr : core_addr;
            op_q    <= pick_ext ? ext_op   : core_op;
            zimm_q  <= pick_ext ? ext_zimm : core_zimm;
            data_q  <= pick_ext ? ext_data : core_data;
         end
         if (state_q == ISSUE) begin
            rdata_q <= csr_rdata;
            err_q   <= !csr_hit;
         end
         if (rsp_done) begin
            last_q <= grant_q;
         end
      end
   end

   assign csr_addr      = addr_q;
   assign csr_op        = op_q;
   assign rs1_zimm      = zimm_q;
   assign rs1_data      = data_q;

   // both ports see the same result registers; only the granted one gets rsp_valid
   assign core_rsp_data = rdata_q;
   assign core_rsp_err  = err_q;
   assign ext_rsp_data  = rdata_q;
   assign ext_rsp_err   = err_q;

endmodule

// File: tb/tb_csr_arbiter.sv
// Directed bench for csr_arbiter: reset state, round robin, field pass-through, errors, stall, reset mid-response.
// Inputs change on negedge or posedge+1, outputs sampled at negedge+1 or later.
// Response ready is driven per scenario to exercise stalls.
module tb_csr_arbiter;
   import types_pkg::*;

   logic    clk = 1'b0;
   logic    reset_n = 1'b0;

   logic    core_valid = 1'b0, core_ready;
   CsrAddrT core_addr = '0;
   csr_op_t core_op = CSR_NONE;
   r        core_zimm = '0;
   word     core_data = '0;
   logic    core_rsp_valid, core_rsp_ready = 1'b0, core_rsp_err;
   word     core_rsp_data;

   logic    ext_valid = 1'b0, ext_ready;
   CsrAddrT ext_addr = '0;
   csr_op_t ext_op = CSR_NONE;
   r        ext_zimm = '0;
   word     ext_data = '0;
   logic    ext_rsp_valid, ext_rsp_ready = 1'b0, ext_rsp_err;
   word     ext_rsp_data;

   logic    csr_enable, csr_hit = 1'b1;
   CsrAddrT csr_addr;
   csr_op_t csr_op;
   r        rs1_zimm;
   word     rs1_data, csr_rdata = '0;

   int      n_checks = 0;
   int      n_fail = 0;
   int      both_rdy = 0;
   int      both_rsp = 0;

   always #5 clk = ~clk;

   csr_arbiter #(.ExtFirst(1'b0)) dut (
      .clk(clk), .reset_n(reset_n),
      .core_valid(core_valid), .core_ready(core_ready), .core_addr(core_addr),
      .core_op(core_op), .core_zimm(core_zimm), .core_data(core_data),
      .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready),
      .core_rsp_data(core_rsp_data), .core_rsp_err(core_rsp_err),
      .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_addr(ext_addr),
      .ext_op(ext_op), .ext_zimm(ext_zimm), .ext_data(ext_data),
      .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready),
      .ext_rsp_data(ext_rsp_data), .ext_rsp_err(ext_rsp_err),
      .csr_enable(csr_enable), .csr_addr(csr_addr), .csr_op(csr_op),
      .rs1_zimm(rs1_zimm), .rs1_data(rs1_data), .csr_rdata(csr_rdata), .csr_hit(csr_hit)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // protocol monitor, sampled mid low phase when all inputs are settled
   always begin
      @(negedge clk);
      #3;
      if (core_ready && ext_ready) both_rdy++;
      if (core_rsp_valid && ext_rsp_valid) both_rsp++;
   end

   // one complete access from a negedge; hold = RESP cycles with rsp_ready low; pend raises the other valid after grant
   task automatic access(input bit ext, input CsrAddrT addr, input csr_op_t op, input r zimm,
                         input word data, input word rdata, input bit hit, input int hold, input bit pend);
      bit got;
      if (ext) begin
         ext_valid = 1'b1; ext_addr = addr; ext_op = op; ext_zimm = zimm; ext_data = data;
         ext_rsp_ready = (hold == 0);
      end else begin
         core_valid = 1'b1; core_addr = addr; core_op = op; core_zimm = zimm; core_data = data;
         core_rsp_ready = (hold == 0);
      end
      csr_rdata = rdata;
      csr_hit   = hit;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         #1;
         if (ext ? ext_ready : core_ready) got = 1'b1;
         else @(negedge clk);
      end
      check_eq("grant", 64'(got), 64'd1);
      check_eq("other_ready_at_grant", 64'(ext ? core_ready : ext_ready), 64'd0);
      @(posedge clk); #1;
      if (ext) ext_valid = 1'b0; else core_valid = 1'b0;
      if (pend) begin
         if (ext) core_valid = 1'b1; else ext_valid = 1'b1;
      end
      @(negedge clk); #1;
      check_eq("issue_enable", 64'(csr_enable), 64'd1);
      check_eq("issue_addr", 64'(csr_addr), 64'(addr));
      check_eq("issue_op", 64'(csr_op), 64'(op));
      check_eq("issue_zimm", 64'(rs1_zimm), 64'(zimm));
      check_eq("issue_data", 64'(rs1_data), 64'(data));
      check_eq("issue_ready", 64'(ext ? ext_ready : core_ready), 64'd0);
      for (int k = 0; k <= hold; k++) begin
         @(negedge clk); #1;
         check_eq("rsp_valid", 64'(ext ? ext_rsp_valid : core_rsp_valid), 64'd1);
         check_eq("rsp_data", 64'(ext ? ext_rsp_data : core_rsp_data), 64'(rdata));
         check_eq("rsp_err", 64'(ext ? ext_rsp_err : core_rsp_err), 64'(!hit));
         check_eq("rsp_other_valid", 64'(ext ? core_rsp_valid : ext_rsp_valid), 64'd0);
         check_eq("rsp_other_ready", 64'(ext ? core_ready : ext_ready), 64'd0);
         check_eq("rsp_enable", 64'(csr_enable), 64'd0);
         if (k < hold) begin
            @(posedge clk); #1;
            if (k + 1 == hold) begin
               if (ext) ext_rsp_ready = 1'b1; else core_rsp_ready = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      ext_rsp_ready  = 1'b0;
      core_rsp_ready = 1'b0;
      @(negedge clk); #1;
      check_eq("done_rsp_valid", 64'(ext ? ext_rsp_valid : core_rsp_valid), 64'd0);
      if (pend) check_eq("pending_granted_after", 64'(ext ? core_ready : ext_ready), 64'd1);
      else      check_eq("idle_enable", 64'(csr_enable), 64'd0);
      @(negedge clk);
   endtask

   initial begin : stim
      int gcyc[3];
      int gport[3];
      int ng;
      int seen;

      // reset state, with a request pending that must not be granted
      core_valid = 1'b1;
      #2;
      check_eq("rst_core_ready", 64'(core_ready), 64'd0);
      check_eq("rst_ext_ready", 64'(ext_ready), 64'd0);
      check_eq("rst_enable", 64'(csr_enable), 64'd0);
      check_eq("rst_core_rsp_valid", 64'(core_rsp_valid), 64'd0);
      check_eq("rst_ext_rsp_valid", 64'(ext_rsp_valid), 64'd0);
      check_eq("rst_rsp_data", 64'(core_rsp_data), 64'd0);
      check_eq("rst_rsp_err", 64'(ext_rsp_err), 64'd0);
      check_eq("rst_csr_addr", 64'(csr_addr), 64'd0);
      check_eq("rst_rs1_data", 64'(rs1_data), 64'd0);
      core_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);

      // round robin from reset: both held valid, expect core, ext, core spaced 3 cycles
      core_valid = 1'b1; core_addr = 12'h100; core_op = CSRRS; core_zimm = '0; core_data = 32'h0;
      ext_valid  = 1'b1; ext_addr  = 12'h200; ext_op  = CSRRS; ext_zimm  = '0; ext_data  = 32'h0;
      core_rsp_ready = 1'b1; ext_rsp_ready = 1'b1; csr_rdata = 32'h77; csr_hit = 1'b1;
      ng = 0;
      for (int c = 0; c < 20 && ng < 3; c++) begin
         #1;
         if (core_ready && ng < 3) begin gcyc[ng] = c; gport[ng] = 0; ng++; end
         if (ext_ready && ng < 3)  begin gcyc[ng] = c; gport[ng] = 1; ng++; end
         if (ng < 3) @(negedge clk);
      end
      check_eq("rr_grant_count", 64'(ng), 64'd3);
      if (ng == 3) begin
         check_eq("rr_first_core", 64'(gport[0]), 64'd0);
         check_eq("rr_second_ext", 64'(gport[1]), 64'd1);
         check_eq("rr_third_core", 64'(gport[2]), 64'd0);
         check_eq("rr_spacing_1", 64'(gcyc[1] - gcyc[0]), 64'd3);
         check_eq("rr_spacing_2", 64'(gcyc[2] - gcyc[1]), 64'd3);
      end
      @(posedge clk); #1;
      core_valid = 1'b0; ext_valid = 1'b0;
      @(negedge clk); @(negedge clk); @(negedge clk);
      #1;
      check_eq("rr_back_idle", 64'(core_rsp_valid | ext_rsp_valid), 64'd0);
      @(negedge clk);
      core_rsp_ready = 1'b0; ext_rsp_ready = 1'b0;

      // core CSRRW
      access(1'b0, 12'h300, CSRRW, 5'd0, 32'hDEADBEEF, 32'h0000_1800, 1'b1, 0, 1'b0);
      // ext CSRRSI with zimm 0
      access(1'b1, 12'h344, CSRRSI, 5'd0, 32'h1234_5678, 32'h0000_0ABC, 1'b1, 0, 1'b0);
      // core access to an undecoded CSR
      access(1'b0, 12'h7FF, CSRRC, 5'd3, 32'h0000_00F0, 32'h0000_55AA, 1'b0, 0, 1'b0);
      // FSM back in IDLE: a plain follow-up access
      access(1'b0, 12'h341, CSRRWI, 5'd17, 32'h0, 32'hCAFE_0001, 1'b1, 0, 1'b0);
      // core stalls response 5 cycles while ext waits
      access(1'b0, 12'h305, CSRRW, 5'd0, 32'h8000_0100, 32'hA5A5_5A5A, 1'b1, 5, 1'b1);
      access(1'b1, 12'h340, CSRRS, 5'd0, 32'h0000_000F, 32'h1111_2222, 1'b1, 0, 1'b0);

      // reset during RESP drops the response asynchronously
      core_valid = 1'b1; core_addr = 12'h342; core_op = CSRRW; core_data = 32'h5;
      core_rsp_ready = 1'b0; csr_rdata = 32'h0000_1234; csr_hit = 1'b1;
      #1;
      check_eq("rstr_grant", 64'(core_ready), 64'd1);
      @(posedge clk); #1;
      core_valid = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      check_eq("rstr_rsp_valid_before", 64'(core_rsp_valid), 64'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check_eq("rstr_rsp_valid_async", 64'(core_rsp_valid), 64'd0);
      check_eq("rstr_rsp_data_async", 64'(core_rsp_data), 64'd0);
      check_eq("rstr_addr_async", 64'(csr_addr), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      core_rsp_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         if (core_rsp_valid || ext_rsp_valid || csr_enable) seen++;
      end
      check_eq("rstr_no_response", 64'(seen), 64'd0);
      core_rsp_ready = 1'b0;
      @(negedge clk);
      access(1'b0, 12'h343, CSRRS, 5'd0, 32'h0, 32'h0000_0042, 1'b1, 1, 1'b0);

      check_eq("never_both_ready", 64'(both_rdy), 64'd0);
      check_eq("never_both_rsp_valid", 64'(both_rsp), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // watchdog so a stuck handshake still ends the run
   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
